// File: rtl/pill_alarm_controller.sv
// pill_alarm_controller: raises an alarm when any of the three pill
// countdowns reaches zero. It then waits for the patient's acknowledge,
// or counts the pending doses as missed after a minute-based timeout.
module pill_alarm_controller #(
  parameter int unsigned TIMEOUT_MIN = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic [11:0] pill12And3Duration,
  input  logic [23:0] bitsFromClock,
  input  logic        ackButton,
  output logic        alarm,
  output logic        buzzer,
  output logic [2:0]  pendingPills,
  output logic [2:0]  takenPulse,
  output logic [7:0]  missedCount,
  output logic [1:0]  alarmState
);

  localparam int unsigned DUR_W   = 12;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned MISS_W  = 8;
  localparam int unsigned SUM_W   = MISS_W + 1;
  localparam logic [3:0]  RUN_MODE = 4'd3;
  localparam logic [MISS_W-1:0] MISS_MAX = 8'd255;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_WATCH    = 2'd1,
    S_RING     = 2'd2
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [DUR_W-1:0]   prev_dur_q;
  logic [DIGIT_W-1:0] prev_sec_q;
  logic [DIGIT_W-1:0] prev_min_q;
  logic               ack_meta_q, ack_sync_q, ack_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pend_d, taken_d;
  logic               buzz_d;
  logic [MISS_W-1:0]  missed_d;

  logic [2:0]         due;
  logic               sec_tick, min_tick, ack_edge, run, timeout_hit;
  logic [SUM_W-1:0]   missed_sum;
  logic [MISS_W-1:0]  missed_sat;

  // Edge detectors: a countdown falling to zero, a digit changing, a button press
  always_comb begin
    due[2]   = (prev_dur_q[11:8] != 4'd0) && (pill12And3Duration[11:8] == 4'd0);
    due[1]   = (prev_dur_q[7:4]  != 4'd0) && (pill12And3Duration[7:4]  == 4'd0);
    due[0]   = (prev_dur_q[3:0]  != 4'd0) && (pill12And3Duration[3:0]  == 4'd0);
    sec_tick = bitsFromClock[3:0]  != prev_sec_q;
    min_tick = bitsFromClock[11:8] != prev_min_q;
    ack_edge = ack_sync_q & ~ack_prev_q;
    run      = (state == RUN_MODE);
  end

  // Timeout detection and saturating miss accumulation
  always_comb begin
    timeout_hit = min_tick && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_MIN));
    missed_sum  = SUM_W'(missedCount) + SUM_W'(pendingPills[2])
                + SUM_W'(pendingPills[1]) + SUM_W'(pendingPills[0]);
    missed_sat  = (missed_sum > SUM_W'(MISS_MAX)) ? MISS_MAX : missed_sum[MISS_W-1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    fsm_d    = fsm_q;
    pend_d   = pendingPills;
    cnt_d    = cnt_q;
    buzz_d   = buzzer;
    taken_d  = 3'b000;
    missed_d = missedCount;

    if (!run) begin
      fsm_d  = S_DISABLED;
      pend_d = 3'b000;
      cnt_d  = '0;
      buzz_d = 1'b0;
    end else begin
      case (fsm_q)
        S_DISABLED: begin
          fsm_d  = S_WATCH;
          pend_d = 3'b000;
          cnt_d  = '0;
          buzz_d = 1'b0;
        end
        S_WATCH: begin
          cnt_d = '0;
          if (due != 3'b000) begin
            fsm_d  = S_RING;
            pend_d = due;
            buzz_d = 1'b1;
          end else begin
            pend_d = 3'b000;
            buzz_d = 1'b0;
          end
        end
        S_RING: begin
          pend_d = pendingPills | due;
          cnt_d  = min_tick ? (cnt_q + CNT_W'(1)) : cnt_q;
          buzz_d = sec_tick ? ~buzzer : buzzer;
          if (ack_edge || timeout_hit) begin
            // Ack takes priority over a coincident timeout
            if (ack_edge) begin
              taken_d = pendingPills;
            end else begin
              missed_d = missed_sat;
            end
            pend_d = due;
            cnt_d  = '0;
            if (due != 3'b000) begin
              fsm_d  = S_RING;
              buzz_d = 1'b1;
            end else begin
              fsm_d  = S_WATCH;
              buzz_d = 1'b0;
            end
          end
        end
        default: begin
          fsm_d  = S_DISABLED;
          pend_d = 3'b000;
          cnt_d  = '0;
          buzz_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_DISABLED;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Previous-value history and ack synchronizer, loaded every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_dur_q <= '0;
      prev_sec_q <= '0;
      prev_min_q <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      prev_dur_q <= pill12And3Duration;
      prev_sec_q <= bitsFromClock[3:0];
      prev_min_q <= bitsFromClock[11:8];
      ack_meta_q <= ackButton;
      ack_sync_q <= ack_meta_q;
      ack_prev_q <= ack_sync_q;
    end
  end

  // Registered outputs and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm        <= 1'b0;
      buzzer       <= 1'b0;
      pendingPills <= 3'b000;
      takenPulse   <= 3'b000;
      missedCount  <= '0;
      cnt_q        <= '0;
    end else begin
      alarm        <= (fsm_d == S_RING);
      buzzer       <= buzz_d;
      pendingPills <= pend_d;
      takenPulse   <= taken_d;
      missedCount  <= missed_d;
      cnt_q        <= cnt_d;
    end
  end

  assign alarmState = fsm_q;

endmodule
